// File: rtl/pooling_stream.sv
// ---------------------------------------------------------------------------
// pooling_stream
//
// Serial pooling engine. It accepts one pixel per cycle over a window of
// cfg_win elements and reduces the selected elements by max or by a shifted
// sum (average). It returns one result per window over a valid/ready
// handshake. A single result is buffered, and input is stalled while it is
// pending.
//
// Optional build feature: define POOL_ARGMAX_EN to add out_idx. This is the
// index of the maximum element in max mode, and the earliest index on ties.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   cfg_win    window length (0 -> 1, >MAX_WIN -> MAX_WIN), sampled on beat 0
//   cfg_mode   0 = max, 1 = average, sampled on beat 0
//   cfg_shift  right shift applied to the sum in average mode, sampled on beat 0
//   in_valid   input beat valid
//   in_ready   block can accept a beat
//   in_data    unsigned pixel
//   in_sel     element participates in the reduction
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   pooled result
//   out_idx    (POOL_ARGMAX_EN only) index of the max element
//   out_cnt    number of selected elements in the window
// ---------------------------------------------------------------------------
module pooling_stream #(
  parameter  int BIT_WIDTH = 8,
  parameter  int MAX_WIN   = 9,
  localparam int CNT_W     = $clog2(MAX_WIN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_W-1:0]     cfg_win,
  input  logic                 cfg_mode,
  input  logic [CNT_W-1:0]     cfg_shift,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic                 in_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
`ifdef POOL_ARGMAX_EN
  output logic [CNT_W-1:0]     out_idx,
`endif
  output logic [CNT_W-1:0]     out_cnt
);

  localparam int               SUM_W     = BIT_WIDTH + CNT_W;
  localparam logic [CNT_W-1:0] MAX_WIN_C = CNT_W'(MAX_WIN);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched window configuration
  logic [CNT_W-1:0]     r_win;
  logic                 r_mode;
  logic [CNT_W-1:0]     r_shift;

  // Running reduction state
  logic [CNT_W-1:0]     r_idx;
  logic [BIT_WIDTH-1:0] r_max;
  logic [SUM_W-1:0]     r_sum;
  logic [CNT_W-1:0]     r_cnt;

  // Result buffer
  logic [BIT_WIDTH-1:0] r_out_data;
  logic [CNT_W-1:0]     r_out_cnt;

  logic                 w_can_accept;
  logic                 w_accept;
  logic                 w_first;
  logic                 w_last;
  logic                 w_take;
  logic [CNT_W-1:0]     w_win_cfg;
  logic [CNT_W-1:0]     w_win;
  logic                 w_mode;
  logic [CNT_W-1:0]     w_shift;
  logic [CNT_W-1:0]     w_idx;
  logic [BIT_WIDTH-1:0] w_max_base;
  logic [SUM_W-1:0]     w_sum_base;
  logic [CNT_W-1:0]     w_cnt_base;
  logic [BIT_WIDTH-1:0] w_max_new;
  logic [SUM_W-1:0]     w_sum_new;
  logic [CNT_W-1:0]     w_cnt_new;

  // Shift the sum right and clamp the result to the pixel range.
  function automatic logic [BIT_WIDTH-1:0] sat_shift(
    input logic [SUM_W-1:0] sum,
    input logic [CNT_W-1:0] sh
  );
    logic [SUM_W-1:0] v;
    v = sum >> sh;
    if (|v[SUM_W-1:BIT_WIDTH]) return {BIT_WIDTH{1'b1}};
    return v[BIT_WIDTH-1:0];
  endfunction

  // Effective window length. Zero means one, and the length is clamped to capacity.
  always_comb begin
    w_win_cfg = cfg_win;
    if (cfg_win == '0)           w_win_cfg = ONE_C;
    else if (cfg_win > MAX_WIN_C) w_win_cfg = MAX_WIN_C;
  end

  // in_ready is forced low while reset is held, not just after its first clock.
  assign w_can_accept = (r_state != S_OUT) && !reset;
  assign w_accept     = in_valid && w_can_accept;
  assign in_ready     = w_can_accept;

  // Beat 0 uses the live config and starts from a clean reduction state.
  // Later beats use the values latched on beat 0.
  assign w_first    = (r_state == S_IDLE);
  assign w_win      = w_first ? w_win_cfg : r_win;
  assign w_mode     = w_first ? cfg_mode  : r_mode;
  assign w_shift    = w_first ? cfg_shift : r_shift;
  assign w_idx      = w_first ? '0 : r_idx;
  assign w_max_base = w_first ? '0 : r_max;
  assign w_sum_base = w_first ? '0 : r_sum;
  assign w_cnt_base = w_first ? '0 : r_cnt;

  // The first selected element is always taken, so that argmax points at it
  // even when its value is 0. Later elements must be strictly greater.
  assign w_take    = in_sel && ((in_data > w_max_base) || (w_cnt_base == '0));
  assign w_max_new = w_take ? in_data : w_max_base;
  assign w_sum_new = w_sum_base + (in_sel ? {{CNT_W{1'b0}}, in_data} : '0);
  assign w_cnt_new = w_cnt_base + {{(CNT_W-1){1'b0}}, in_sel};
  assign w_last    = (w_idx == (w_win - ONE_C));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_last ? S_OUT : S_ACCUM;
      S_ACCUM: if (w_accept && w_last) w_state_nxt = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Accumulate stage: the running state updates on every accepted beat.
  // The result buffer loads on the last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win      <= '0;
      r_mode     <= 1'b0;
      r_shift    <= '0;
      r_idx      <= '0;
      r_max      <= '0;
      r_sum      <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
      r_out_cnt  <= '0;
    end else if (w_accept) begin
      r_idx <= w_idx + ONE_C;
      r_max <= w_max_new;
      r_sum <= w_sum_new;
      r_cnt <= w_cnt_new;
      if (w_first) begin
        r_win   <= w_win_cfg;
        r_mode  <= cfg_mode;
        r_shift <= cfg_shift;
      end
      if (w_last) begin
        r_out_data <= w_mode ? sat_shift(w_sum_new, w_shift) : w_max_new;
        r_out_cnt  <= w_cnt_new;
      end
    end
  end

  assign out_data = r_out_data;
  assign out_cnt  = r_out_cnt;

`ifdef POOL_ARGMAX_EN
  logic [CNT_W-1:0] r_arg;
  logic [CNT_W-1:0] r_out_idx;
  logic [CNT_W-1:0] w_arg_new;

  assign w_arg_new = w_take ? w_idx : (w_first ? '0 : r_arg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arg     <= '0;
      r_out_idx <= '0;
    end else if (w_accept) begin
      r_arg <= w_arg_new;
      if (w_last) r_out_idx <= w_mode ? '0 : w_arg_new;
    end
  end

  assign out_idx = r_out_idx;
`endif

endmodule

// File: tb/tb_pooling_stream.sv
// ---------------------------------------------------------------------------
// tb_pooling_stream
//
// Directed bench for pooling_stream with hand-computed expected values.
// It covers max and average modes, selection masks, saturation, window
// clamping, backpressure, input bubbles, and reset in the middle of a window.
// ---------------------------------------------------------------------------
module tb_pooling_stream;

  localparam int BW    = 8;
  localparam int MW    = 9;
  localparam int CW    = $clog2(MW + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] cfg_win;
  logic          cfg_mode;
  logic [CW-1:0] cfg_shift;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          in_sel;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [CW-1:0] out_cnt;
`ifdef POOL_ARGMAX_EN
  logic [CW-1:0] out_idx;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [BW-1:0] td [MW];
  logic          ts [MW];

  always #5 clk = ~clk;

  pooling_stream #(.BIT_WIDTH(BW), .MAX_WIN(MW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_win   (cfg_win),
    .cfg_mode  (cfg_mode),
    .cfg_shift (cfg_shift),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef POOL_ARGMAX_EN
    .out_idx   (out_idx),
`endif
    .out_cnt   (out_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Data 10,20,...,90 with the selection taken from mask bit i.
  task automatic fill_ramp(input logic [8:0] mask);
    for (int i = 0; i < MW; i++) begin
      td[i] = BW'(10 * (i + 1));
      ts[i] = mask[i];
    end
  endtask

  // Drive n beats from td/ts. The config is only valid on beat 0; later beats
  // drive conflicting config, which must be ignored.
  task automatic run_win(input int n, input logic [CW-1:0] win, input logic mode,
                         input logic [CW-1:0] sh, input bit bub);
    for (int i = 0; i < n; i++) begin
      if (bub) begin
        for (int k = 0; k < 3; k++) begin
          if ($urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
      end
      in_valid = 1'b1;
      in_data  = td[i];
      in_sel   = ts[i];
      if (i == 0) begin
        cfg_win = win; cfg_mode = mode; cfg_shift = sh;
      end else begin
        cfg_win = CW'(1); cfg_mode = ~mode; cfg_shift = '0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i == n - 2) chk("no_early_valid", out_valid, 0);
    end
    chk("valid_after_last", out_valid, 1);
  endtask

  task automatic take_out(input string tag, input int ed, input int ec,
                          input int ei, input int hold);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_valid"},   out_valid, 1);
    chk({tag, "_data"},    out_data, ed);
    chk({tag, "_cnt"},     out_cnt, ec);
`ifdef POOL_ARGMAX_EN
    chk({tag, "_idx"},     out_idx, ei);
`else
    if (ei < 0) $display("note: negative index for %s", tag);
`endif
    chk({tag, "_inrdy0"},  in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drained"}, out_valid, 0);
    chk({tag, "_inrdy1"},  in_ready, 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
    cfg_win = '0; cfg_mode = 1'b0; cfg_shift = '0; out_ready = 1'b0;
    #3;
    chk("rst_inrdy", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_cnt",   out_cnt, 0);
    @(negedge clk); reset = 1'b0; #1;
    chk("post_rst_inrdy", in_ready, 1);
    @(posedge clk); #1;

    // Max mode, all selected, with backpressure held for 5 cycles
    fill_ramp(9'h1FF);
    run_win(9, CW'(9), 1'b0, '0, 1'b0);
    take_out("max_all_bp", 90, 9, 8, 5);

    // Same window with random input bubbles
    run_win(9, CW'(9), 1'b0, '0, 1'b1);
    take_out("max_bubbles", 90, 9, 8, 0);

    // Only elements 3..5 selected
    fill_ramp(9'b000111000);
    run_win(9, CW'(9), 1'b0, '0, 1'b0);
    take_out("max_sel345", 60, 3, 5, 0);

    // Only element 2 selected
    fill_ramp(9'b000000100);
    run_win(9, CW'(9), 1'b0, '0, 1'b0);
    take_out("max_sel2", 30, 1, 2, 0);

    // Nothing selected, both modes
    fill_ramp(9'h000);
    run_win(9, CW'(9), 1'b0, '0, 1'b0);
    take_out("max_none", 0, 0, 0, 0);
    run_win(9, CW'(9), 1'b1, '0, 1'b0);
    take_out("avg_none", 0, 0, 0, 0);

    // Tie keeps the earliest value
    td[0] = 8'd50; td[1] = 8'd50; td[2] = 8'd20;
    ts[0] = 1'b1;  ts[1] = 1'b1;  ts[2] = 1'b1;
    run_win(3, CW'(3), 1'b0, '0, 1'b0);
    take_out("max_tie", 50, 3, 0, 0);

    // Average: (10+20+30+40)>>2 = 25
    fill_ramp(9'h1FF);
    run_win(4, CW'(4), 1'b1, CW'(2), 1'b0);
    take_out("avg_shift2", 25, 4, 0, 0);

    // Average: 4*255 = 1020. Shift 0 saturates; 1020>>3 = 127.
    for (int i = 0; i < 4; i++) begin td[i] = 8'd255; ts[i] = 1'b1; end
    run_win(4, CW'(4), 1'b1, '0, 1'b0);
    take_out("avg_sat", 255, 4, 0, 0);
    run_win(4, CW'(4), 1'b1, CW'(3), 1'b0);
    take_out("avg_shift3", 127, 4, 0, 0);

    // cfg_win = 0 acts as a window of one
    td[0] = 8'd42; ts[0] = 1'b1;
    run_win(1, '0, 1'b0, '0, 1'b0);
    take_out("win0", 42, 1, 0, 0);

    // cfg_win = 15 is clamped to 9
    for (int i = 0; i < MW; i++) begin td[i] = BW'(i + 1); ts[i] = 1'b1; end
    run_win(9, CW'(15), 1'b0, '0, 1'b0);
    take_out("win_clamp", 9, 9, 8, 0);

    // Reset after 3 beats of a 9-element window
    fill_ramp(9'h1FF);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = td[i]; in_sel = 1'b1;
      cfg_win = CW'(9); cfg_mode = 1'b0; cfg_shift = '0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1; #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data",  out_data, 0);
    chk("midrst_cnt",   out_cnt, 0);
    chk("midrst_inrdy", in_ready, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_idle_valid", out_valid, 0);
    td[0] = 8'd5; td[1] = 8'd7; ts[0] = 1'b1; ts[1] = 1'b1;
    run_win(2, CW'(2), 1'b0, '0, 1'b0);
    take_out("after_rst", 7, 2, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pooling_stream.md
Name: pooling_stream

Overview:
Streaming pooling engine for the CNN MACC datapath. It accepts one pixel per cycle over a runtime-configurable window of up to MAX_WIN elements. Each element carries a select bit. The block reduces the selected elements by max or average and returns one result per window over a valid/ready handshake. It replaces the fixed 9-input combinational max pooler with a serial, parametrised, two-mode unit that sits between the convolution output buffer and the activation write-back.

Parameters:
- BIT_WIDTH, 8: unsigned pixel width.
- MAX_WIN, 9: maximum window length, in elements.
- CNT_W, $clog2(MAX_WIN+1): counter width. Local parameter, derived.

Ports:
- clk, input, 1: clock; all logic is rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- cfg_win, input, CNT_W: window length.
  - Sampled on the first accepted beat of each window.
  - 0 is treated as 1; values above MAX_WIN are clamped to MAX_WIN.
- cfg_mode, input, 1: 0 = max, 1 = average. Sampled with cfg_win.
- cfg_shift, input, CNT_W: right-shift applied to the sum in average mode. Sampled with cfg_win.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block can accept a beat.
- in_data, input, BIT_WIDTH: pixel value.
- in_sel, input, 1: element participates in the reduction.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, BIT_WIDTH: pooled result.
- out_cnt, output, CNT_W: number of selected elements in the window.

Behaviour:
- Reset values:
  - in_ready = 0 while reset is asserted, 1 in the first cycle after deassertion.
  - out_valid = 0, out_data = 0, out_cnt = 0.
  - All accumulators, counters and latched configuration are cleared; FSM = IDLE.
- A beat is accepted when in_valid && in_ready.
- FSM states:
  - IDLE: in_ready = 1. An accepted beat latches the configuration, processes element 0 and moves to ACCUM. If the effective window length is 1, it moves directly to OUT.
  - ACCUM: in_ready = 1. Each accepted beat increments the element index. When the beat with index = eff_win-1 is accepted, the state moves to OUT.
  - OUT: in_ready = 0 and out_valid = 1. out_data and out_cnt are stable until out_valid && out_ready, which returns the state to IDLE.
- Latency: out_valid rises in the cycle after the last beat is accepted. The block buffers exactly one result, with no result/input overlap; throughput is eff_win+1 cycles per window when out_ready is held high.
- in_valid low mid-window inserts a bubble; the window does not time out.
- Max mode:
  - Running max starts at 0.
  - A selected element replaces the running max only if strictly greater, so ties keep the earliest value.
  - Unselected elements are ignored.
- Average mode:
  - Sum register is BIT_WIDTH+CNT_W bits; it cannot overflow for MAX_WIN elements.
  - out_data = sum >> cfg_shift, saturated to 2^BIT_WIDTH-1 if the shifted value exceeds BIT_WIDTH bits.
  - The shift is not a divide by out_cnt; the software sets cfg_shift.
- No selected elements in a window: out_data = 0 and out_cnt = 0 in both modes.
- cfg_* changes mid-window have no effect until the next window starts.
- Reset asserted mid-window or in OUT discards the partial or pending result. No output is produced for it.

Optional Feature:
- Macro: POOL_ARGMAX_EN.
- When defined:
  - Adds output out_idx, width CNT_W: the element index of the max in max mode, i.e. the earliest index on ties.
  - out_idx is 0 in average mode or when no elements are selected.
  - out_idx resets to 0 and is stable with out_data.
- When undefined: the port and the index register are absent, and behaviour is otherwise identical.

Test Plan:
- Window 9, max mode, data 10,20,…,90, all selected → out_data = 90, out_cnt = 9; out_valid the cycle after the 9th beat. With POOL_ARGMAX_EN, out_idx = 8.
- Window 9, max mode, select only elements 3–5 (40,50,60) → out_data = 60, out_cnt = 3. Select only element 2 → out_data = 30, out_cnt = 1.
- Window 9, no elements selected → out_data = 0, out_cnt = 0, in both modes.
- Window 4, average mode, shift 2, data 10,20,30,40 all selected → out_data = 25. Data 255 ×4 with shift 0 → out_data saturates to 255.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles after out_valid; out_data is stable and in_ready = 0.
  - Then pulse out_ready; the next window starts the following cycle.
  - Toggle in_valid randomly mid-window; the result is unchanged.
- Assert reset after 3 beats of a 9-element window → all outputs 0. A fresh window of 5,7 (cfg_win = 2, max mode) then yields 7.
